arb_req_master: RTL and testbench

Requester-side counterpart to the 4-input static fixed-priority arbiter. Holds N independent channel state machines. Each channel accepts a job from local logic, raises its `req` line, and holds the line until it has received exactly the requested number of granted cycles. It then releases the line and pulses `done`. It sits between client datapaths and the arbiter: `req` goes to the arbiter, and the combinational `grant` comes back.

---
 rtl/arb_req_master_pkg.sv | 15 +
 rtl/arb_req_master_if.sv | 25 ++
 rtl/arb_req_master_chan.sv | 120 ++++++++++++
 rtl/arb_req_master.sv | 42 ++++
 tb/tb_arb_req_master.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/arb_req_master_pkg.sv
// Shared channel state type and default sizing for the arbiter request master.
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_OWN  = 2'd2,
    ST_REL  = 2'd3
  } chan_state_e;

  localparam int N_DEF       = 4;
  localparam int LEN_W_DEF   = 4;
  localparam int TIMEOUT_DEF = 200;

endpackage

// File: rtl/arb_req_master_if.sv
// Request/grant bundle between client logic, the request master and the arbiter.
interface arb_req_master_if
  import arb_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int LEN_W = LEN_W_DEF
);
  logic [N-1:0]       start;
  logic [N*LEN_W-1:0] len;
  logic [N-1:0]       req;
  logic [N-1:0]       grant;
  logic [N-1:0]       busy;
  logic [N-1:0]       done;
  logic [N-1:0]       starve;

  modport master (
    input  start, len, grant,
    output req, busy, done, starve
  );

  modport slave (
    output start, len, grant,
    input  req, busy, done, starve
  );
endinterface

// File: rtl/arb_req_master_chan.sv
// One requester channel: holds req until max(len,1) granted beats, then pulses done.
// Optional starvation watchdog is built only when ARB_REQ_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no job; start captures len
// REQ   | req raised, first beat not yet granted
// OWN   | at least one beat granted, more remaining
// REL   | req dropped, done pulse, back to IDLE next
module arb_req_chan
  import arb_pkg::*;
#(
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             grant_i,
  output logic             req_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             starve_o
);

  chan_state_e      state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          rem_d   = (len_i == '0) ? LEN_W'(1) : len_i;
          state_d = ST_REQ;
        end
      end
      ST_REQ, ST_OWN: begin
        // An ungranted cycle (preemption) leaves the beat count untouched.
        if (grant_i) begin
          if (rem_q == LEN_W'(1)) begin
            state_d = ST_REL;
          end else begin
            rem_d   = rem_q - LEN_W'(1);
            state_d = ST_OWN;
          end
        end
      end
      ST_REL:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    req_d  = (state_d == ST_REQ) || (state_d == ST_OWN);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_REL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign req_o  = req_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

`ifdef ARB_REQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              starve_q, starve_d;

  always_comb begin
    wait_d   = wait_q;
    starve_d = starve_q;
    if (req_q && !grant_i) begin
      if (wait_q != WAIT_W'(TIMEOUT)) wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = '0;
    end
    // Flag is visible the cycle after the TIMEOUT-th consecutive ungranted cycle.
    if ((state_q == ST_IDLE) && start_i) begin
      starve_d = 1'b0;
    end else if (wait_d == WAIT_W'(TIMEOUT)) begin
      starve_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q   <= '0;
      starve_q <= 1'b0;
    end else begin
      wait_q   <= wait_d;
      starve_q <= starve_d;
    end
  end

  assign starve_o = starve_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign starve_o       = 1'b0;
`endif

endmodule

// File: rtl/arb_req_master.sv
// N independent request channels facing a fixed-priority arbiter; this level only slices the bus.
// Starvation flags are live only when ARB_REQ_TIMEOUT_EN is defined.
module arb_req_master
  import arb_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  arb_req_master_if.master bus
);

  logic [N-1:0] req_w;
  logic [N-1:0] busy_w;
  logic [N-1:0] done_w;
  logic [N-1:0] starve_w;

  for (genvar i = 0; i < N; i++) begin : g_chan
    arb_req_chan #(
      .LEN_W   (LEN_W),
      .TIMEOUT (TIMEOUT)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (bus.start[i]),
      .len_i    (bus.len[i*LEN_W +: LEN_W]),
      .grant_i  (bus.grant[i]),
      .req_o    (req_w[i]),
      .busy_o   (busy_w[i]),
      .done_o   (done_w[i]),
      .starve_o (starve_w[i])
    );
  end

  assign bus.req    = req_w;
  assign bus.busy   = busy_w;
  assign bus.done   = done_w;
  assign bus.starve = starve_w;

endmodule

// File: tb/tb_arb_req_master.sv
// Bench for arb_req_master: fixed-priority arbiter model, directed table, corner sequences, random vs model.
module tb_arb_req_master;
  import arb_pkg::*;

  localparam int N  = 4;
  localparam int LW = 4;
  localparam int TO = 8;
  localparam bit TO_EN =
`ifdef ARB_REQ_TIMEOUT_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic gate = 1'b1;
  always #5 clk = ~clk;

  arb_req_master_if #(.N(N), .LEN_W(LW)) bus ();

  arb_req_master #(.N(N), .LEN_W(LW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [N-1:0] fp_arb(input logic [N-1:0] r);
    logic [N-1:0] g;
    g = '0;
    for (int i = 0; i < N; i++) if (r[i] && (g == '0)) g[i] = 1'b1;
    return g;
  endfunction

  assign bus.grant = gate ? fp_arb(bus.req) : '0;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [N-1:0]    start;
    logic [N*LW-1:0] len;
    logic [N-1:0]    req;
    logic [N-1:0]    busy;
    logic [N-1:0]    done;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] s, input logic [15:0] l,
                     input logic [3:0] r, input logic [3:0] b, input logic [3:0] d);
    vec_t v;
    v.start = s; v.len = l; v.req = r; v.busy = b; v.done = d;
    tbl.push_back(v);
  endtask

  // Behavioural reference: beats outstanding per channel plus a release flag.
  int           left[N];
  bit           rel[N];
  int           wcnt[N];
  bit           stv[N];
  logic [N-1:0] mreq, mg, s_r, e_req, e_busy, e_done, e_stv;
  logic [15:0]  l_r;
  int           nib;

  initial begin
    bus.start = '0;
    bus.len   = '0;

    // Reset behaviour
    #12;
    check("rst req",    bus.req,    4'b0000);
    check("rst busy",   bus.busy,   4'b0000);
    check("rst done",   bus.done,   4'b0000);
    check("rst starve", bus.starve, 4'b0000);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("post-rst req c%0d", c), bus.req, 4'b0000);
    end

    // Single channel len 3
    add(4'b0100, 16'h0300, 4'b0100, 4'b0100, 4'b0000);
    add(4'b0000, 16'h0000, 4'b0100, 4'b0100, 4'b0000);
    add(4'b0000, 16'h0000, 4'b0100, 4'b0100, 4'b0000);
    add(4'b0000, 16'h0000, 4'b0000, 4'b0100, 4'b0100);
    add(4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000);
    // Two channels contending
    add(4'b1001, 16'h2002, 4'b1001, 4'b1001, 4'b0000);
    add(4'b0000, 16'h0000, 4'b1001, 4'b1001, 4'b0000);
    add(4'b0000, 16'h0000, 4'b1000, 4'b1001, 4'b0001);
    add(4'b0000, 16'h0000, 4'b1000, 4'b1000, 4'b0000);
    add(4'b0000, 16'h0000, 4'b0000, 4'b1000, 4'b1000);
    add(4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000);
    // Preemption of ch1 by ch0
    add(4'b0010, 16'h0040, 4'b0010, 4'b0010, 4'b0000);
    add(4'b0000, 16'h0000, 4'b0010, 4'b0010, 4'b0000);
    add(4'b0001, 16'h0002, 4'b0011, 4'b0011, 4'b0000);
    add(4'b0000, 16'h0000, 4'b0011, 4'b0011, 4'b0000);
    add(4'b0000, 16'h0000, 4'b0010, 4'b0011, 4'b0001);
    add(4'b0000, 16'h0000, 4'b0010, 4'b0010, 4'b0000);
    add(4'b0000, 16'h0000, 4'b0000, 4'b0010, 4'b0010);
    add(4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000);
    // Zero length, ignored restart, then back-to-back acceptance on ch0
    add(4'b0010, 16'h0000, 4'b0010, 4'b0010, 4'b0000);
    add(4'b0010, 16'h0000, 4'b0000, 4'b0010, 4'b0010);
    add(4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 16'h0001, 4'b0001, 4'b0001, 4'b0000);
    add(4'b0000, 16'h0000, 4'b0000, 4'b0001, 4'b0001);
    add(4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000);

    foreach (tbl[k]) begin
      bus.start = tbl[k].start;
      bus.len   = tbl[k].len;
      step();
      check($sformatf("tbl%0d req", k),    bus.req,    tbl[k].req);
      check($sformatf("tbl%0d busy", k),   bus.busy,   tbl[k].busy);
      check($sformatf("tbl%0d done", k),   bus.done,   tbl[k].done);
      check($sformatf("tbl%0d starve", k), bus.starve, 4'b0000);
    end
    bus.start = '0;
    bus.len   = '0;

    // Starvation: ch3 held off for 12 cycles
    gate      = 1'b0;
    bus.start = 4'b1000;
    bus.len   = 16'h2000;
    step();
    bus.start = '0;
    for (int c = 1; c <= 12; c++) begin
      check($sformatf("starve c%0d", c), bus.starve, (TO_EN && c >= 9) ? 4'b1000 : 4'b0000);
      check($sformatf("starve req c%0d", c), bus.req, 4'b1000);
      step();
    end
    gate = 1'b1;
    step();
    step();
    check("starve job done",   bus.done,   4'b1000);
    check("starve job req",    bus.req,    4'b0000);
    check("starve sticky",     bus.starve, TO_EN ? 4'b1000 : 4'b0000);
    step();
    check("starve idle busy",  bus.busy,   4'b0000);
    check("starve idle hold",  bus.starve, TO_EN ? 4'b1000 : 4'b0000);

    // New start clears the flag; reset mid-job drops it silently
    bus.start = 4'b1000;
    bus.len   = 16'h5000;
    step();
    bus.start = '0;
    check("restart clears starve", bus.starve, 4'b0000);
    check("restart busy",          bus.busy,   4'b1000);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("midjob rst req",  bus.req,  4'b0000);
    check("midjob rst busy", bus.busy, 4'b0000);
    check("midjob rst done", bus.done, 4'b0000);
    step();
    #2 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("after rst c%0d", c), {bus.req, bus.busy, bus.done}, 12'h000);
    end

    // Randomised traffic against the reference model
    for (int i = 0; i < N; i++) begin
      left[i] = 0; rel[i] = 1'b0; wcnt[i] = 0; stv[i] = 1'b0;
    end
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < N; i++) s_r[i] = ($urandom_range(3) == 0);
      l_r = 16'($urandom);
      for (int i = 0; i < N; i++) mreq[i] = (left[i] > 0);
      mg = fp_arb(mreq);
      for (int i = 0; i < N; i++) begin
        nib = int'(l_r[i*LW +: LW]);
        if (rel[i]) begin
          rel[i] = 1'b0;
        end else if (left[i] > 0) begin
          if (mg[i]) begin
            left[i]--;
            wcnt[i] = 0;
            if (left[i] == 0) rel[i] = 1'b1;
          end else begin
            wcnt[i]++;
            if (wcnt[i] >= TO) stv[i] = 1'b1;
          end
        end else if (s_r[i]) begin
          left[i] = (nib == 0) ? 1 : nib;
          wcnt[i] = 0;
          stv[i]  = 1'b0;
        end
      end
      for (int i = 0; i < N; i++) begin
        e_req[i]  = (left[i] > 0);
        e_busy[i] = (left[i] > 0) || rel[i];
        e_done[i] = rel[i];
        e_stv[i]  = TO_EN && stv[i];
      end
      bus.start = s_r;
      bus.len   = l_r;
      step();
      check($sformatf("rand t%0d {req,busy,done,starve}", t),
            {bus.req, bus.busy, bus.done, bus.starve}, {e_req, e_busy, e_done, e_stv});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
